// File: rtl/gpio_params_pkg.sv
// Shared definitions for the GPIO parameter bridge: command opcodes and
// helpers that locate the command fields inside a GPIO word.
package gpio_params_pkg;

    // Number of opcode bits at the top of every command word.
    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP    = 3'b000,
        CMD_READ   = 3'b001,
        CMD_RSV2   = 3'b010,
        CMD_RSV3   = 3'b011,
        CMD_WR_LO  = 3'b100,
        CMD_WR_HI  = 3'b101,
        CMD_COMMIT = 3'b110,
        CMD_INFO   = 3'b111
    } cmd_e;

    // Lowest bit of the opcode field for a GPIO word of width w.
    function automatic int cmd_lsb(input int w);
        return w - CMD_W;
    endfunction

    // Width of the argument field (lower half of the word).
    function automatic int arg_w(input int w);
        return w / 2;
    endfunction

    // Width needed to address n parameters; never zero.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_param_bank.sv
// Parameter bank: either a combinational mirror of the default values or a
// bank of registers reset-loaded from them, with one write port and a read mux.
module gpio_param_bank
    import gpio_params_pkg::*;
#(
    parameter int GPIO_WIDTH  = 32,
    parameter int PARAM_COUNT = 16,
    parameter int SET         = 0,
    parameter int IDX_W       = 4
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic [GPIO_WIDTH*PARAM_COUNT-1:0] params_data,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [GPIO_WIDTH-1:0]             wr_data,
    input  logic [IDX_W-1:0]                  rd_idx,
    output logic [GPIO_WIDTH-1:0]             rd_data,
    output logic [GPIO_WIDTH*PARAM_COUNT-1:0] params_out
);

    localparam int W = GPIO_WIDTH;

    logic [W-1:0] bank_w [PARAM_COUNT];

    genvar gi;

    generate
        if (SET != 0) begin : g_regs
            for (gi = 0; gi < PARAM_COUNT; gi++) begin : g_word
                logic [W-1:0] word_q;
                logic [W-1:0] word_d;

                // Take the staged value when this word is the commit target.
                always_comb begin
                    word_d = word_q;
                    if (wr_en && (wr_idx == IDX_W'(gi))) begin
                        word_d = wr_data;
                    end
                end

                // Reset reloads the default; afterwards the defaults are ignored.
                always_ff @(posedge clk) begin
                    if (srst) begin
                        word_q <= params_data[gi*W +: W];
                    end else begin
                        word_q <= word_d;
                    end
                end

                assign bank_w[gi] = word_q;
            end
        end else begin : g_mirror
            for (gi = 0; gi < PARAM_COUNT; gi++) begin : g_word
                assign bank_w[gi] = params_data[gi*W +: W];
            end
            // The write port and clock have no effect on a mirrored bank.
            logic unused_write_port;
            assign unused_write_port = ^{clk, srst, wr_en, wr_idx, wr_data};
        end
    endgenerate

    generate
        for (gi = 0; gi < PARAM_COUNT; gi++) begin : g_out
            assign params_out[gi*W +: W] = bank_w[gi];
        end
    endgenerate

    // Read mux; indices that decode to no parameter read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < PARAM_COUNT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = bank_w[i];
            end
        end
    end

endmodule

// File: rtl/gpio_params.sv
// GPIO parameter bridge: registers the command word, executes it once per
// change, maintains the staging word and drives the registered response.
module gpio_params
    import gpio_params_pkg::*;
#(
    parameter int GPIO_WIDTH  = 32,
    parameter int PARAM_COUNT = 16,
    parameter int SET         = 0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [GPIO_WIDTH-1:0]             GP_IN,
    output logic [GPIO_WIDTH-1:0]             GP_OUT,
    input  logic [GPIO_WIDTH*PARAM_COUNT-1:0] PARAMS_DATA,
    output logic [GPIO_WIDTH*PARAM_COUNT-1:0] PARAMS_OUT
);

    localparam int W     = GPIO_WIDTH;
    localparam int H     = arg_w(GPIO_WIDTH);
    localparam int IDX_W = idx_w(PARAM_COUNT);

    // Count with one extra bit so PARAM_COUNT = 2^H still compares correctly.
    localparam logic [H:0]   COUNT_V   = (H+1)'(PARAM_COUNT);
    localparam logic [W-1:0] INFO_WORD = W'(PARAM_COUNT);

    logic [W-1:0] gp_q, gp_d;
    logic [W-1:0] gp_prev_q, gp_prev_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] stage_q, stage_d;

    logic         fire;
    cmd_e         cmd;
    logic [H-1:0] arg;
    logic         arg_in_range;
    logic         wr_en;
    logic [W-1:0] rd_data;

    assign fire         = (gp_q != gp_prev_q);
    assign cmd          = cmd_e'(gp_q[cmd_lsb(W) +: CMD_W]);
    assign arg          = gp_q[H-1:0];
    assign arg_in_range = ({1'b0, arg} < COUNT_V);

    // Decode the registered command; act only on the cycle after a change.
    always_comb begin
        gp_d      = GP_IN;
        gp_prev_d = gp_q;
        out_d     = out_q;
        stage_d   = stage_q;
        wr_en     = 1'b0;
        if (fire) begin
            case (cmd)
                CMD_READ: begin
                    out_d = arg_in_range ? rd_data : '0;
                end
                CMD_WR_LO: begin
                    stage_d = {stage_q[W-1:H], arg};
                    out_d   = stage_d;
                end
                CMD_WR_HI: begin
                    stage_d = {arg, stage_q[H-1:0]};
                    out_d   = stage_d;
                end
                CMD_COMMIT: begin
                    if ((SET != 0) && arg_in_range) begin
                        wr_en = 1'b1;
                        out_d = stage_q;
                    end else begin
                        out_d = '0;
                    end
                end
                CMD_INFO: begin
                    out_d = INFO_WORD;
                end
                default: begin
                end
            endcase
        end
    end

    // Command pipeline, staging word and response register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gp_q      <= '0;
            gp_prev_q <= '0;
            out_q     <= '0;
            stage_q   <= '0;
        end else begin
            gp_q      <= gp_d;
            gp_prev_q <= gp_prev_d;
            out_q     <= out_d;
            stage_q   <= stage_d;
        end
    end

    assign GP_OUT = out_q;

    gpio_param_bank #(
        .GPIO_WIDTH  (GPIO_WIDTH),
        .PARAM_COUNT (PARAM_COUNT),
        .SET         (SET),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk         (CLK),
        .srst        (RST),
        .params_data (PARAMS_DATA),
        .wr_en       (wr_en),
        .wr_idx      (arg[IDX_W-1:0]),
        .wr_data     (stage_q),
        .rd_idx      (arg[IDX_W-1:0]),
        .rd_data     (rd_data),
        .params_out  (PARAMS_OUT)
    );

endmodule

// File: tb/tb_gpio_params.sv
// Bench for gpio_params: a mirrored (SET=0) and a register-backed (SET=1)
// instance share the command stream; both are compared against a command-level
// model of the parameter bank, staging word and response.
module tb_gpio_params;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  gp_in;
    logic [511:0] pdata;
    logic [31:0]  out0, out1;
    logic [511:0] pout0, pout1;

    always #5 clk = ~clk;

    gpio_params #(.GPIO_WIDTH(32), .PARAM_COUNT(16), .SET(0)) dut0 (
        .CLK(clk), .RST(rst), .GP_IN(gp_in), .GP_OUT(out0),
        .PARAMS_DATA(pdata), .PARAMS_OUT(pout0)
    );

    gpio_params #(.GPIO_WIDTH(32), .PARAM_COUNT(16), .SET(1)) dut1 (
        .CLK(clk), .RST(rst), .GP_IN(gp_in), .GP_OUT(out1),
        .PARAMS_DATA(pdata), .PARAMS_OUT(pout1)
    );

    // Reference state: defaults, writable bank, per-instance staging/response.
    logic [31:0] pd    [16];
    logic [31:0] mbank [16];
    logic [31:0] mstage[2];
    logic [31:0] mout  [2];
    logic [31:0] mprev;

    int n_asserts = 0;
    int n_fail    = 0;

    function automatic logic [511:0] pack_pd();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = pd[i];
        return r;
    endfunction

    function automatic logic [511:0] pack_bank();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = mbank[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A word executes once when it differs from the previously issued word.
    task automatic model_exec(input logic [31:0] w);
        logic [2:0]  c;
        logic [15:0] a;
        if (w != mprev) begin
            mprev = w;
            c = w[31:29];
            a = w[15:0];
            for (int s = 0; s < 2; s++) begin
                case (c)
                    3'b001: mout[s] = (a < 16) ? ((s == 1) ? mbank[a[3:0]] : pd[a[3:0]]) : 32'h0;
                    3'b100: begin mstage[s][15:0]  = a; mout[s] = mstage[s]; end
                    3'b101: begin mstage[s][31:16] = a; mout[s] = mstage[s]; end
                    3'b110: begin
                        if (s == 1 && a < 16) begin
                            mbank[a[3:0]] = mstage[s];
                            mout[s] = mstage[s];
                        end else begin
                            mout[s] = 32'h0;
                        end
                    end
                    3'b111: mout[s] = 32'd16;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mbank[i] = pd[i];
        mstage[0] = 0; mstage[1] = 0;
        mout[0] = 0;   mout[1] = 0;
        mprev = 0;
    endtask

    // Issue one word, hold it four cycles, check response latency and bank.
    task automatic apply(input logic [31:0] w);
        logic [31:0] o0, o1;
        @(negedge clk);
        gp_in = w;
        o0 = mout[0];
        o1 = mout[1];
        model_exec(w);
        @(posedge clk); #1;
        chk($sformatf("out0_edge1 w=%h", w), out0, o0);
        chk($sformatf("out1_edge1 w=%h", w), out1, o1);
        @(posedge clk); #1;
        chk($sformatf("out0 w=%h", w), out0, mout[0]);
        chk($sformatf("out1 w=%h", w), out1, mout[1]);
        chk($sformatf("pout0 w=%h", w), pout0, pack_pd());
        chk($sformatf("pout1 w=%h", w), pout1, pack_bank());
        @(posedge clk);
    endtask

    // Issue a word, then assert reset on the edge where it would execute.
    task automatic reset_over(input logic [31:0] w);
        @(negedge clk);
        gp_in = w;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out0", out0, 32'h0);
        chk("rst_out1", out1, 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        gp_in = 32'h0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("post_rst_out0", out0, mout[0]);
        chk("post_rst_out1", out1, mout[1]);
        chk("post_rst_pout0", pout0, pack_pd());
        chk("post_rst_pout1", pout1, pack_bank());
    endtask

    initial begin
        logic [31:0] w, last_w;
        logic [15:0] a;

        rst   = 1'b1;
        gp_in = 32'h0;
        for (int i = 0; i < 16; i++) pd[i] = i;
        pdata = pack_pd();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out0", out0, 32'h0);
        chk("reset_out1", out1, 32'h0);
        chk("reset_pout0", pout0, pack_pd());
        chk("reset_pout1", pout1, pack_pd());
        @(negedge clk);
        rst = 1'b0;

        // Read every parameter, then one index past the end.
        for (int i = 0; i < 16; i++) apply(32'h2000_0000 + i);
        apply(32'h2000_0010);
        chk("oob_read0", out0, 32'h0);

        // Stage, commit and read back index 3.
        apply(32'h8000_BEEF);
        chk("plan_wrlo", out1, 32'h0000_BEEF);
        apply(32'hA000_DEAD);
        chk("plan_wrhi", out1, 32'hDEAD_BEEF);
        apply(32'hC000_0003);
        chk("plan_commit1", out1, 32'hDEAD_BEEF);
        chk("plan_commit0", out0, 32'h0);
        apply(32'h2000_0003);
        chk("plan_read1", out1, 32'hDEAD_BEEF);
        chk("plan_read0", out0, 32'h3);
        chk("plan_pout1", pout1[127:96], 32'hDEAD_BEEF);

        // A held word executes only once; re-issue needs a differing word.
        apply(32'h2000_0005);
        repeat (16) begin
            @(posedge clk); #1;
            chk("hold_out0", out0, 32'h5);
            chk("hold_out1", out1, 32'h5);
        end
        apply(32'h0000_0000);
        apply(32'h2000_0005);
        chk("reissue_out1", out1, 32'h5);

        apply(32'hE000_0000);
        chk("info", out1, 32'd16);

        // Reset during a staging sequence discards staging and overrides a commit.
        apply(32'h8000_1234);
        reset_over(32'hC000_0003);
        apply(32'hA000_0001);
        chk("wrhi_after_rst", out1, 32'h0001_0000);

        // Defaults changing after reset reach the mirror only.
        @(negedge clk);
        for (int i = 0; i < 16; i++) pd[i] = $urandom();
        pdata = pack_pd();
        #1;
        chk("pd_change_pout0", pout0, pack_pd());
        chk("pd_change_pout1", pout1, pack_bank());

        // Random command stream, with occasional repeats and out-of-range args.
        last_w = mprev;
        repeat (60) begin
            a = ($urandom_range(0, 4) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 17));
            w = {3'($urandom_range(0, 7)), 13'($urandom()), a};
            if ($urandom_range(0, 5) == 0) w = last_w;
            apply(w);
            last_w = w;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_params.md
# gpio_params

Parameter-access bridge between a processor GPIO channel and the fabric. The processor drives a command word on `GP_IN` and reads the response on `GP_OUT`. The block exposes a bank of `PARAM_COUNT` words of `GPIO_WIDTH` bits each. The bank is read-only, mirroring `PARAMS_DATA`, when `SET=0`. When `SET=1` the bank is register-backed, reset-loaded from `PARAMS_DATA` and writable over GPIO. The bank drives downstream processing through `PARAMS_OUT`.

## Interface
- `GPIO_WIDTH`, 32: width of GPIO words and of each parameter. Must be even and ≥ 8.
- `PARAM_COUNT`, 16: number of parameters, 1 to 2^(GPIO_WIDTH/2).
- `SET`, 0: 0 means the bank is a combinational mirror of `PARAMS_DATA` and writes are ignored; 1 means the bank is writable registers.
- `CLK`  in  1  single clock. `GP_IN` is synchronous to it.
- `RST`  in  1  synchronous, active-high reset.
- `GP_IN`  in  `GPIO_WIDTH`  command word.
- `GP_OUT`  out  `GPIO_WIDTH`  registered response.
- `PARAMS_DATA`  in  `GPIO_WIDTH*PARAM_COUNT`  default/mirror values. Parameter i is at `[i*GPIO_WIDTH +: GPIO_WIDTH]`.
- `PARAMS_OUT`  out  `GPIO_WIDTH*PARAM_COUNT`  current bank contents, same packing as `PARAMS_DATA`.

## Operation
- Definitions: H = `GPIO_WIDTH`/2, W = `GPIO_WIDTH`.
- Command fields: CMD = `GP_IN[W-1:W-3]`; ARG = `GP_IN[H-1:0]`. The remaining bits are ignored.
- Commands execute only when the registered `GP_IN` differs from its previous registered value.
  - Software re-issues an identical command by inserting a NOP or any other differing word in between.
- CMD 3'b000 NOP: no action; `GP_OUT` holds.
- CMD 3'b001 READ: `GP_OUT` ← param[ARG]. If ARG ≥ `PARAM_COUNT`, `GP_OUT` ← 0.
- CMD 3'b100 WR_LO: staging[H-1:0] ← ARG; `GP_OUT` ← the updated staging word.
- CMD 3'b101 WR_HI: staging[W-1:H] ← ARG; `GP_OUT` ← the updated staging word.
- CMD 3'b110 COMMIT, ARG is the index:
  - With `SET=1` and ARG < `PARAM_COUNT`: param[ARG] ← staging and `GP_OUT` ← staging.
  - Otherwise nothing is written and `GP_OUT` ← 0.
- CMD 3'b111 INFO: `GP_OUT` ← `PARAM_COUNT` zero-extended.
- CMD 3'b010 and 3'b011 are reserved and behave as NOP.
- Staging is kept across commands. It is used by both `SET` variants but only committed when `SET=1`.
- With `SET=0`, param[i] and `PARAMS_OUT` track `PARAMS_DATA` combinationally.

## Timing
- Edge 1 after a `GP_IN` change: `gp_q` ← `GP_IN`, `gp_prev` ← `gp_q`. The fire condition is `gp_q != gp_prev`.
- Edge 2: the command executes. `GP_OUT`, staging and the bank update on this edge.
- Response latency is 2 `CLK` edges from the `GP_IN` change. Software must hold each word ≥ 3 cycles.
- A READ following a COMMIT to the same index returns the new value.
- Reset values: `GP_OUT` = 0, staging = 0, `gp_q` = `gp_prev` = 0, bank = `PARAMS_DATA` (`SET=1`).
- The first non-zero `GP_IN` after reset fires once.
- `RST` overrides any command on the same edge. Reset during a WR_LO/WR_HI/COMMIT sequence discards staging.
- A `PARAMS_DATA` change after reset does not affect the bank when `SET=1`.

## Structure
- Shared package `gpio_params_pkg`: CMD opcode constants (NOP, READ, WR_LO, WR_HI, COMMIT, INFO) and field-position helper constants.
- Sub-module `gpio_param_bank`: generate-selected mirror or register bank with write port and read mux. The top level holds the change detector, decoder, staging register and `GP_OUT`.

## Test plan
All scenarios use W=32, `PARAM_COUNT`=16, and `PARAMS_DATA` with param i = i.
- `SET=0`: drive `GP_IN` = 0x2000_0000 through 0x2000_000F, each held 4 cycles.
  - `GP_OUT` = 0x0 through 0xF respectively, each 2 edges after its change.
- Out-of-range read: 0x2000_0010 → `GP_OUT` = 0.
- `SET=1` write sequence: 0x8000_BEEF, 0xA000_DEAD, 0xC000_0003.
  - `GP_OUT` = 0x0000_BEEF, then 0xDEAD_BEEF, then 0xDEAD_BEEF.
  - A following read 0x2000_0003 → 0xDEAD_BEEF; `PARAMS_OUT[127:96]` = 0xDEAD_BEEF.
- Same sequence with `SET=0`: COMMIT → `GP_OUT` = 0; read 0x2000_0003 → 3.
- Hold 0x2000_0005 for 20 cycles, then 0x0000_0000, then 0x2000_0005.
  - Exactly two READ executions; `GP_OUT` stays 5 throughout.
- INFO and reset:
  - 0xE000_0000 → `GP_OUT` = 16.
  - `RST` after 0x8000_1234 → `GP_OUT` = 0 and the bank equals `PARAMS_DATA`.
  - A subsequent WR_HI 0xA000_0001 → `GP_OUT` = 0x0001_0000.
